// File: rtl/vscale_fetch_redirect_ctrl.sv
// rtl/vscale_fetch_redirect_ctrl.sv - fetch-redirect arbiter with a one-entry pending redirect register
// Optional redirect statistics counter enabled by defining VSCALE_REDIRECT_STATS_EN.
module vscale_fetch_redirect_ctrl #(
    parameter int XPR_LEN = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               imem_wait,
    input  logic               stall_DX,
    input  logic               exception_WB,
    input  logic               eret_WB,
    input  logic               jal_DX,
    input  logic               jalr_DX,
    input  logic               branch_taken_DX,
    input  logic [XPR_LEN-1:0] PC_target,
    output logic [2:0]         PC_src_sel,
    output logic               stall_IF,
    output logic               kill_IF,
    output logic               kill_DX,
    output logic               use_pend,
    output logic [XPR_LEN-1:0] pend_PC
`ifdef VSCALE_REDIRECT_STATS_EN
    ,
    output logic [31:0]        redirect_count
`endif
);

    localparam logic [2:0] PC_PLUS_FOUR = 3'd0;
    localparam logic [2:0] PC_BRANCH    = 3'd1;
    localparam logic [2:0] PC_JAL       = 3'd2;
    localparam logic [2:0] PC_JALR      = 3'd3;
    localparam logic [2:0] PC_REPLAY    = 3'd4;
    localparam logic [2:0] PC_HANDLER   = 3'd5;
    localparam logic [2:0] PC_EPC       = 3'd6;

    typedef enum logic {
        RUN,
        PEND
    } state_t;

    state_t             state, state_next;
    logic [XPR_LEN-1:0] pend_q;
    logic               wb_redirect;
    logic               dx_ok;
    logic               redirect;
    logic [2:0]         sel_r;
    logic               capture;
    logic               accept;

    assign wb_redirect = exception_WB | eret_WB;
    // A WB redirect kills DX, so DX sources are qualified by its absence.
    assign dx_ok       = !stall_DX && !wb_redirect;

    always_comb begin
        redirect = 1'b1;
        sel_r    = PC_PLUS_FOUR;
        if (exception_WB)                 sel_r = PC_HANDLER;
        else if (eret_WB)                 sel_r = PC_EPC;
        else if (dx_ok && jalr_DX)        sel_r = PC_JALR;
        else if (dx_ok && jal_DX)         sel_r = PC_JAL;
        else if (dx_ok && branch_taken_DX) sel_r = PC_BRANCH;
        else                              redirect = 1'b0;
    end

    always_comb begin
        state_next = state;
        PC_src_sel = PC_PLUS_FOUR;
        stall_IF   = 1'b1;
        kill_IF    = 1'b0;
        kill_DX    = 1'b0;
        use_pend   = 1'b0;
        capture    = 1'b0;
        accept     = 1'b0;
        if (reset_n) begin
            kill_DX = wb_redirect;
            case (state)
                RUN: begin
                    if (redirect) begin
                        PC_src_sel = sel_r;
                        kill_IF    = 1'b1;
                        stall_IF   = imem_wait;
                        accept     = 1'b1;
                        if (imem_wait) begin
                            capture    = 1'b1;
                            state_next = PEND;
                        end
                    end else begin
                        PC_src_sel = imem_wait ? PC_REPLAY : PC_PLUS_FOUR;
                        stall_IF   = imem_wait | stall_DX;
                    end
                end
                PEND: begin
                    use_pend = 1'b1;
                    kill_IF  = 1'b1;
                    // An overwrite holds fetch one more cycle so the new target is replayed, never the stale one.
                    if (wb_redirect) begin
                        PC_src_sel = sel_r;
                        stall_IF   = 1'b1;
                        capture    = 1'b1;
                        accept     = 1'b1;
                    end else begin
                        PC_src_sel = PC_REPLAY;
                        stall_IF   = imem_wait;
                        if (!imem_wait) state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RUN;
            pend_q <= '0;
        end else begin
            state <= state_next;
            if (capture) pend_q <= PC_target;
        end
    end

    assign pend_PC = pend_q;

`ifdef VSCALE_REDIRECT_STATS_EN
    logic [31:0] redirect_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    redirect_count_q <= '0;
        else if (accept) redirect_count_q <= redirect_count_q + 32'd1;
    end

    assign redirect_count = redirect_count_q;
`endif

endmodule

// File: doc/vscale_fetch_redirect_ctrl.md
# vscale_fetch_redirect_ctrl

Fetch-redirect controller sitting between the pipeline control unit and the PC mux. It arbitrates the redirect sources, drives `PC_src_sel`, `stall_IF` and the IF/DX kill signals every cycle, and computes the next-PC select by fixed priority. A redirect that arrives while instruction memory is stalled is captured in a one-entry pending register and replayed once memory is ready, so no redirect is ever lost.

## Interface
- `XPR_LEN`, default 32: PC width.
- `clk` input 1: sole clock; all state updates on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `imem_wait` input 1: instruction memory not ready this cycle.
- `stall_DX` input 1: DX hazard stall; DX-sourced redirects are not taken while high.
- `exception_WB` input 1: trap taken; select handler.
- `eret_WB` input 1: exception return; select EPC.
- `jal_DX`, `jalr_DX`, `branch_taken_DX` input 1 each: DX control-flow requests.
- `PC_target` input XPR_LEN: PC mux pre-stall sum (`base + offset`) for the current select.
- `PC_src_sel` output 3: encodings from vscale_ctrl_constants.vh: PLUS_FOUR=0, BRANCH=1, JAL=2, JALR=3, REPLAY=4, HANDLER=5, EPC=6.
- `stall_IF` output 1: hold PC_IF.
- `kill_IF` output 1: squash the instruction currently in IF.
- `kill_DX` output 1: squash the instruction currently in DX.
- `use_pend` output 1: PC mux must take `pend_PC` instead of its own sum.
- `pend_PC` output XPR_LEN: captured redirect target.
- `redirect_count` output 32: present only with `VSCALE_REDIRECT_STATS_EN`.

## Operation
- Priority: exception_WB > eret_WB > jalr_DX > jal_DX > branch_taken_DX. DX sources are qualified by `!stall_DX` and `!kill_DX`.
- `redirect` = any qualified source is active. `sel_r` = encoding of the winning source.
- FSM states:
  - RUN: `use_pend`=0.
    - redirect && !imem_wait: `PC_src_sel`=sel_r, `stall_IF`=0, `kill_IF`=1. Stay in RUN.
    - redirect && imem_wait: `PC_src_sel`=sel_r, `stall_IF`=1, `kill_IF`=1. Capture `pend_PC`<=`PC_target`, go to PEND.
    - No redirect: `PC_src_sel`=REPLAY if imem_wait, else PLUS_FOUR. `stall_IF`=imem_wait|stall_DX.
  - PEND: `use_pend`=1, `PC_src_sel`=REPLAY, `kill_IF`=1.
    - A new exception or eret overwrites `pend_PC` with `PC_target` (its sel is driven that cycle). DX redirects are ignored.
    - !imem_wait: `stall_IF`=0, so `PC_PIF`=`pend_PC`. Go to RUN.
    - imem_wait: `stall_IF`=1. Stay in PEND.
- `kill_DX`=1 whenever exception_WB or eret_WB is high, in any state.
- Reset: state=RUN, `pend_PC`=0, `redirect_count`=0. Combinational outputs under reset: `PC_src_sel`=PLUS_FOUR, `stall_IF`=1, `kill_IF`=0, `kill_DX`=0, `use_pend`=0.
- Deasserting `reset_n` mid-PEND discards the pending redirect.

## Timing
- Select, stall and kill outputs are combinational, same cycle as their inputs.
- Redirect with no wait: the target is fetched the next cycle, for 1 cycle of redirect penalty.
- Redirect during wait: the target is presented on the first cycle with `imem_wait`=0. The FSM is back in RUN at the following edge.
- Exception and eret in the same cycle: exception wins and eret is dropped.
- Exception together with a DX redirect: the DX redirect is dropped and `kill_DX`=1.
- `pend_PC` updates only on its capture or overwrite edge. Otherwise it holds.

## Configuration
- `VSCALE_REDIRECT_STATS_EN` defined:
  - 32-bit `redirect_count` increments once per accepted redirect, i.e. RUN entries with redirect plus PEND overwrites.
  - Wraps from 0xFFFFFFFF to 0.
  - Reset to 0.
- Undefined: the port and counter are absent and the remaining behaviour is identical.

## Test plan
- Reset with `reset_n`=0, then release, with no requests: `PC_src_sel`=0, `stall_IF`=0, `kill_IF`=0, state RUN.
- `branch_taken_DX`=1, `imem_wait`=0: `PC_src_sel`=1 and `kill_IF`=1 in the same cycle. Next cycle PLUS_FOUR.
- `jalr_DX`=1, `imem_wait`=1 for 3 cycles, `PC_target`=0x200:
  - `pend_PC`=0x200, `use_pend`=1, `stall_IF`=1 for the remaining wait cycles.
  - `stall_IF`=0 on the cycle `imem_wait` falls.
  - RUN after that.
- In PEND with `pend_PC`=0x200, `exception_WB`=1, `PC_target`=0x100: `pend_PC` becomes 0x100 and `kill_DX`=1. Then release the wait: 0x100 is fetched.
- `exception_WB`, `eret_WB` and `jal_DX` together: `PC_src_sel`=5, `kill_DX`=1. With `jal_DX` and `stall_DX`=1: no redirect, `stall_IF`=1.
- With `VSCALE_REDIRECT_STATS_EN` and the counter forced to 0xFFFFFFFF: one branch redirect gives `redirect_count`=0. Async reset mid-PEND gives RUN, `pend_PC`=0 and counter 0.
